// File: rtl/dekatron_pkg.sv
// Shared dekatron definitions: guide-pulse codes, decoder states and one-hot helpers
// used by the decoder and by the sender/bulb models.
package dekatron_pkg;

  localparam int MAX_MOD = 10;

  typedef logic [MAX_MOD-1:0] pos_t;

  // Pair is {L_n, R_n}; both lines idle high.
  typedef enum logic [1:0] {
    PULSE_FAIL  = 2'b00,
    PULSE_LEFT  = 2'b01,
    PULSE_RIGHT = 2'b10,
    PULSE_NONE  = 2'b11
  } pulse_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FWD1,
    ST_FWD2,
    ST_REV1,
    ST_REV2,
    ST_FAIL
  } state_e;

  function automatic pos_t pos_mask(int n);
    return (pos_t'(1) << n) - pos_t'(1);
  endfunction

  // Rotations stay within the low n bits of the ring.
  function automatic pos_t rot_left(pos_t v, int n);
    return ((v << 1) | (v >> (n - 1))) & pos_mask(n);
  endfunction

  function automatic pos_t rot_right(pos_t v, int n);
    return ((v >> 1) | (v << (n - 1))) & pos_mask(n);
  endfunction

  function automatic logic is_onehot(pos_t v, int n);
    return $countones(v & pos_mask(n)) == 1;
  endfunction

  function automatic logic [3:0] onehot_idx(pos_t v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_MOD; i++)
      if (v[i[3:0]]) idx = i[3:0];
    return idx;
  endfunction

endpackage

// File: rtl/dekatron_if.sv
// Decoder-side bundle: control/load inputs and decoded position, strobes and status.
interface dekatron_if #(parameter int COUNT_MOD = 10);
  logic                 en;
  logic                 pulse_right_n;
  logic                 pulse_left_n;
  logic                 load;
  logic [COUNT_MOD-1:0] load_value;
  logic                 err_clr;
  logic [COUNT_MOD-1:0] out;
  logic [3:0]           digit;
  logic                 step_fwd;
  logic                 step_rev;
  logic                 abort;
  logic                 ready;
  logic                 proto_err;

  modport master (
    output en, pulse_right_n, pulse_left_n, load, load_value, err_clr,
    input  out, digit, step_fwd, step_rev, abort, ready, proto_err
  );

  modport slave (
    input  en, pulse_right_n, pulse_left_n, load, load_value, err_clr,
    output out, digit, step_fwd, step_rev, abort, ready, proto_err
  );
endinterface

// File: rtl/dekatron_sync.sv
// Plain flop-chain synchroniser with a configurable reset value (idle-high lines preset to 1).
module dekatron_sync #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [DEPTH-1:0][WIDTH-1:0] r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_q <= {DEPTH{RST_VAL}};
    else       r_q <= {r_q[DEPTH-2:0], i_d};
  end

  assign o_q = r_q[DEPTH-1];
endmodule

// File: rtl/dekatron_pulse_decoder.sv
// Decodes two-phase dekatron guide pulses into forward/reverse steps and tracks
// the cathode position as one-hot word plus digit, flagging protocol errors.
module dekatron_pulse_decoder
  import dekatron_pkg::*;
#(
  parameter int COUNT_MOD   = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic      i_clk,
  input  logic      i_rst,
  dekatron_if.slave io_bus
);
  logic                 w_r_n, w_l_n;
  pulse_e               w_p;
  pos_t                 w_rl_ext, w_rr_ext;
  logic                 w_load_ok;

  state_e               r_state;
  logic [COUNT_MOD-1:0] r_out;
  logic [3:0]           r_digit;
  logic                 r_fwd, r_rev, r_abort, r_ready, r_err;

  dekatron_sync #(.WIDTH(1), .DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_r (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(io_bus.pulse_right_n), .o_q(w_r_n)
  );
  dekatron_sync #(.WIDTH(1), .DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_l (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(io_bus.pulse_left_n), .o_q(w_l_n)
  );

  assign w_p       = pulse_e'({w_l_n, w_r_n});
  assign w_rl_ext  = rot_left(pos_t'(r_out), COUNT_MOD);
  assign w_rr_ext  = rot_right(pos_t'(r_out), COUNT_MOD);
  assign w_load_ok = is_onehot(pos_t'(io_bus.load_value), COUNT_MOD);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_out   <= COUNT_MOD'(1);
      r_digit <= '0;
      r_fwd   <= 1'b0;
      r_rev   <= 1'b0;
      r_abort <= 1'b0;
      r_ready <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      r_fwd   <= 1'b0;
      r_rev   <= 1'b0;
      r_abort <= 1'b0;
      // Rest code always leads back to IDLE, so it alone decides Ready.
      r_ready <= (w_p == PULSE_NONE);
      if (io_bus.err_clr) r_err <= 1'b0;

      if (!io_bus.en) begin
        r_state <= ST_IDLE;
      end else if (w_p == PULSE_FAIL) begin
        r_state <= ST_FAIL;
        r_err   <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE:
            if (w_p == PULSE_RIGHT)     r_state <= ST_FWD1;
            else if (w_p == PULSE_LEFT) r_state <= ST_REV1;
          ST_FWD1:
            if (w_p == PULSE_LEFT) r_state <= ST_FWD2;
            else if (w_p == PULSE_NONE) begin
              r_state <= ST_IDLE;
              r_abort <= 1'b1;
            end
          ST_FWD2:
            if (w_p == PULSE_RIGHT) r_state <= ST_FWD1;
            else if (w_p == PULSE_NONE) begin
              r_state <= ST_IDLE;
              r_fwd   <= 1'b1;
              r_out   <= w_rl_ext[COUNT_MOD-1:0];
              r_digit <= onehot_idx(w_rl_ext);
            end
          ST_REV1:
            if (w_p == PULSE_RIGHT) r_state <= ST_REV2;
            else if (w_p == PULSE_NONE) begin
              r_state <= ST_IDLE;
              r_abort <= 1'b1;
            end
          ST_REV2:
            if (w_p == PULSE_LEFT) r_state <= ST_REV1;
            else if (w_p == PULSE_NONE) begin
              r_state <= ST_IDLE;
              r_rev   <= 1'b1;
              r_out   <= w_rr_ext[COUNT_MOD-1:0];
              r_digit <= onehot_idx(w_rr_ext);
            end
          ST_FAIL:
            if (w_p == PULSE_NONE) r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end

      // Placed last so a load overrides any rotation in the same cycle.
      if (io_bus.load) begin
        if (w_load_ok) begin
          r_out   <= io_bus.load_value;
          r_digit <= onehot_idx(pos_t'(io_bus.load_value));
        end else begin
          r_err   <= 1'b1;
        end
      end
    end
  end

  assign io_bus.out       = r_out;
  assign io_bus.digit     = r_digit;
  assign io_bus.step_fwd  = r_fwd;
  assign io_bus.step_rev  = r_rev;
  assign io_bus.abort     = r_abort;
  assign io_bus.ready     = r_ready;
  assign io_bus.proto_err = r_err;
endmodule

// File: tb/tb_dekatron_pulse_decoder.sv
// Bench for the dekatron pulse decoder: ring sizes 10 and 8 driven with identical guide pulses.
module tb_dekatron_pulse_decoder;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1, r_n = 1'b1, l_n = 1'b1, load = 1'b0, err_clr = 1'b0;
  logic [9:0] lv = '0;

  always #5 clk = ~clk;

  dekatron_if #(.COUNT_MOD(10)) bus10 ();
  dekatron_if #(.COUNT_MOD(8))  bus8 ();

  assign bus10.en = en;  assign bus10.pulse_right_n = r_n;  assign bus10.pulse_left_n = l_n;
  assign bus10.load = load;  assign bus10.load_value = lv;  assign bus10.err_clr = err_clr;
  assign bus8.en = en;   assign bus8.pulse_right_n = r_n;   assign bus8.pulse_left_n = l_n;
  assign bus8.load = load;   assign bus8.load_value = lv[7:0]; assign bus8.err_clr = err_clr;

  dekatron_pulse_decoder #(.COUNT_MOD(10), .SYNC_STAGES(SYNC)) u_dut10 (
    .i_clk(clk), .i_rst(rst), .io_bus(bus10)
  );
  dekatron_pulse_decoder #(.COUNT_MOD(8), .SYNC_STAGES(SYNC)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .io_bus(bus8)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a step completes when the lines return to rest after the
  // last active phase differs from the first one; same-as-first means abort.
  logic [1:0] sh [SYNC];
  logic [1:0] p, last;
  int         dir;          // 0 at rest, 1 forward (began RIGHT), 2 reverse (began LEFT)
  bit         fail, e_fwd, e_rev, e_ab, e_ready, fsm_err;
  int         mpos [2];
  bit         merr [2];
  int         cnt_f = 0, cnt_r = 0, cnt_a = 0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC; i++) sh[i] = 2'b11;
      dir = 0; last = 2'b11; fail = 0;
      e_fwd = 0; e_rev = 0; e_ab = 0; e_ready = 1;
      for (int k = 0; k < 2; k++) begin mpos[k] = 0; merr[k] = 0; end
    end else begin
      p = sh[SYNC-1];
      for (int i = SYNC-1; i > 0; i--) sh[i] = sh[i-1];
      sh[0] = {l_n, r_n};
      e_fwd = 0; e_rev = 0; e_ab = 0; fsm_err = 0;
      e_ready = (p == 2'b11);
      if (!en) begin
        dir = 0; fail = 0;
      end else if (p == 2'b00) begin
        fail = 1; dir = 0; fsm_err = 1;
      end else if (p == 2'b11) begin
        if (!fail && dir != 0) begin
          if (last != ((dir == 1) ? 2'b10 : 2'b01)) begin
            e_fwd = (dir == 1); e_rev = (dir == 2);
          end else e_ab = 1;
        end
        dir = 0; fail = 0;
      end else if (!fail) begin
        if (dir == 0) dir = (p == 2'b10) ? 1 : 2;
        last = p;
      end
      for (int k = 0; k < 2; k++) begin
        int m;
        bit lerr;
        logic [9:0] masked;
        m = (k == 0) ? 10 : 8;
        lerr = 0;
        if (e_fwd) mpos[k] = (mpos[k] + 1) % m;
        if (e_rev) mpos[k] = (mpos[k] + m - 1) % m;
        if (load) begin
          masked = lv & ((k == 0) ? 10'h3FF : 10'h0FF);
          if ($countones(masked) == 1) begin
            for (int j = 0; j < 10; j++) if (masked[j[3:0]]) mpos[k] = j;
          end else lerr = 1;
        end
        if (err_clr) merr[k] = 0;
        if (fsm_err || lerr) merr[k] = 1;
      end
    end
    #1;
    chk("out10",   32'(bus10.out),   32'(1) << mpos[0]);
    chk("digit10", 32'(bus10.digit), 32'(mpos[0]));
    chk("out8",    32'(bus8.out),    32'(1) << mpos[1]);
    chk("digit8",  32'(bus8.digit),  32'(mpos[1]));
    chk("err10",   32'(bus10.proto_err), 32'(merr[0]));
    chk("err8",    32'(bus8.proto_err),  32'(merr[1]));
    chk("strobes10", {29'b0, bus10.step_fwd, bus10.step_rev, bus10.abort}, {29'b0, e_fwd, e_rev, e_ab});
    chk("strobes8",  {29'b0, bus8.step_fwd, bus8.step_rev, bus8.abort},    {29'b0, e_fwd, e_rev, e_ab});
    chk("ready10", 32'(bus10.ready), 32'(e_ready));
    chk("ready8",  32'(bus8.ready),  32'(e_ready));
    if (bus10.step_fwd) cnt_f++;
    if (bus10.step_rev) cnt_r++;
    if (bus10.abort)    cnt_a++;
  end

  task automatic ph(input logic [1:0] c, input int n);
    {l_n, r_n} = c;
    repeat (n) @(negedge clk);
  endtask

  task automatic fwd_step();
    ph(2'b11, 4); ph(2'b10, 4); ph(2'b01, 4); ph(2'b11, 4);
  endtask

  task automatic do_reset();
    {l_n, r_n} = 2'b11; en = 1; load = 0; err_clr = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic do_load(input logic [9:0] v, input logic clr);
    lv = v; load = 1; err_clr = clr;
    @(negedge clk);
    load = 0; err_clr = 0;
  endtask

  int f0, r0, a0;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out10", 32'(bus10.out), 32'd1);
    chk("rst_digit10", 32'(bus10.digit), 32'd0);
    chk("rst_ready", 32'(bus10.ready), 32'd1);
    chk("rst_err", 32'(bus10.proto_err), 32'd0);
    rst = 0;

    // Three forward steps
    f0 = cnt_f;
    repeat (3) fwd_step();
    chk("fwd3_out10", 32'(bus10.out), 32'b0000001000);
    chk("fwd3_digit10", 32'(bus10.digit), 32'd3);
    chk("fwd3_count", 32'(cnt_f - f0), 32'd3);
    chk("fwd3_model", 32'(mpos[0]), 32'd3);

    // Reverse from reset wraps to top of ring
    do_reset();
    r0 = cnt_r;
    ph(2'b11, 4); ph(2'b01, 4); ph(2'b10, 4); ph(2'b11, 4);
    chk("rev_out10", 32'(bus10.out), 32'b1000000000);
    chk("rev_digit10", 32'(bus10.digit), 32'd9);
    chk("rev_digit8", 32'(bus8.digit), 32'd7);
    chk("rev_count", 32'(cnt_r - r0), 32'd1);

    // Eight forward steps: octotron returns to 0
    do_reset();
    repeat (8) fwd_step();
    chk("oct_out8", 32'(bus8.out), 32'b00000001);
    chk("oct_digit8", 32'(bus8.digit), 32'd0);
    chk("oct_digit10", 32'(bus10.digit), 32'd8);

    // Abort then back-stepped forward sequence
    do_reset();
    a0 = cnt_a; f0 = cnt_f;
    ph(2'b11, 4); ph(2'b10, 4);
    chk("half_ready", 32'(bus10.ready), 32'd0);
    ph(2'b11, 4);
    chk("abort_count", 32'(cnt_a - a0), 32'd1);
    chk("abort_out10", 32'(bus10.out), 32'd1);
    ph(2'b10, 4); ph(2'b01, 4); ph(2'b10, 4); ph(2'b01, 4); ph(2'b11, 4);
    chk("backstep_count", 32'(cnt_f - f0), 32'd1);
    chk("backstep_digit", 32'(bus10.digit), 32'd1);

    // 00 mid-step: error, no strobe, not ready until rest
    f0 = cnt_f; a0 = cnt_a;
    ph(2'b10, 4); ph(2'b00, 4);
    chk("fail_err", 32'(bus10.proto_err), 32'd1);
    chk("fail_ready", 32'(bus10.ready), 32'd0);
    ph(2'b01, 3);
    chk("fail_ready2", 32'(bus10.ready), 32'd0);
    ph(2'b11, 4);
    chk("fail_ready3", 32'(bus10.ready), 32'd1);
    chk("fail_nostrobe", 32'((cnt_f - f0) + (cnt_a - a0)), 32'd0);
    err_clr = 1; @(negedge clk); err_clr = 0;
    chk("errclr", 32'(bus10.proto_err), 32'd0);

    // Loads: valid, invalid, and clear colliding with a new error
    do_load(10'b0000100000, 1'b0);
    chk("load_digit10", 32'(bus10.digit), 32'd5);
    chk("load_digit8", 32'(bus8.digit), 32'd5);
    do_load(10'b0000000110, 1'b0);
    chk("badload_err", 32'(bus10.proto_err), 32'd1);
    chk("badload_out", 32'(bus10.out), 32'b0000100000);
    do_load(10'b0000000110, 1'b1);
    chk("clr_vs_err", 32'(bus10.proto_err), 32'd1);

    // Load coincident with the step strobe cycle: load wins, strobe kept
    f0 = cnt_f;
    ph(2'b10, 4); ph(2'b01, 4);
    {l_n, r_n} = 2'b11;
    repeat (2) @(negedge clk);
    do_load(10'b0100000000, 1'b0);
    ph(2'b11, 3);
    chk("ldstep_count", 32'(cnt_f - f0), 32'd1);
    chk("ldstep_digit", 32'(bus10.digit), 32'd8);

    // En low drops an in-flight half-step silently; 00 ignored while disabled
    a0 = cnt_a; f0 = cnt_f;
    ph(2'b10, 4); ph(2'b01, 2);
    en = 0;
    ph(2'b01, 2); ph(2'b00, 3); ph(2'b11, 2);
    en = 1;
    ph(2'b11, 4);
    chk("en_nostrobe", 32'((cnt_a - a0) + (cnt_f - f0)), 32'd0);
    chk("en_digit", 32'(bus10.digit), 32'd8);

    // Reset while in FWD2: no step survives
    f0 = cnt_f;
    ph(2'b10, 4); ph(2'b01, 4);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    ph(2'b11, 6);
    chk("rst_fwd2_out", 32'(bus10.out), 32'd1);
    chk("rst_fwd2_nostep", 32'(cnt_f - f0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
